// File: rtl/common.sv
// common: shared types and constants for the instruction-side memory.
package common;
   typedef logic [31:0] instruction_type;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic [1:0] {IDLE, LOAD, DONE} imem_load_state_t;
endpackage

// File: rtl/imem_byte_loader.sv
// imem_byte_loader: byte-serial program loader FSM; assembles little-endian
// words and issues one array write per fourth accepted byte.
module imem_byte_loader
   import common::*;
#(
   parameter int DEPTH_WORDS = 1024,
   localparam int ADDR_W = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_words,
   input  logic [7:0]        load_byte,
   input  logic              load_valid,
   output logic              load_ready,
   output logic              busy,
   output logic              load_done,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       wdata
);
   localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(DEPTH_WORDS);
   imem_load_state_t  state;
   logic [ADDR_W-1:0] wr_ptr, last;
   logic [ADDR_W:0]   n_words;
   logic [1:0]        byte_cnt;
   logic [23:0]       sh;
   assign n_words = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
   assign we = load_ready && load_valid && byte_cnt == 2'd3;
   assign waddr = wr_ptr;
   assign wdata = {load_byte, sh};
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         busy       <= 1'b0;
         load_ready <= 1'b0;
         load_done  <= 1'b0;
         wr_ptr     <= '0;
         last       <= '0;
         byte_cnt   <= '0;
         sh         <= '0;
      end else begin
         load_done <= 1'b0;
         case (state)
            IDLE: if (load_start) begin
               wr_ptr   <= '0;
               byte_cnt <= '0;
               last     <= n_words[ADDR_W-1:0] - ADDR_W'(1);
               if (n_words == '0) load_done <= 1'b1;
               else begin
                  state      <= LOAD;
                  busy       <= 1'b1;
                  load_ready <= 1'b1;
               end
            end
            LOAD: if (load_valid) begin
               sh       <= {load_byte, sh[23:8]};
               byte_cnt <= byte_cnt + 2'd1;
               // last word ends the load without advancing wr_ptr past the array
               if (byte_cnt == 2'd3) begin
                  if (wr_ptr == last) begin
                     state      <= DONE;
                     load_ready <= 1'b0;
                     load_done  <= 1'b1;
                  end else wr_ptr <= wr_ptr + ADDR_W'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/instr_mem_responder.sv
// instr_mem_responder: combinational-read instruction memory with byte-serial loader.
// Defining IMEM_PARITY_EN adds per-word even parity with parity_inject/parity_err.
module instr_mem_responder
   import common::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_WORD    = NOP_INSTR,
   localparam int         ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [31:0]     address,
   output instruction_type data,
   output logic            fetch_fault,
   input  logic            load_start,
   input  logic [ADDR_W:0] load_words,
   input  logic [7:0]      load_byte,
   input  logic            load_valid,
   output logic            load_ready,
   output logic            busy,
   output logic            load_done
`ifdef IMEM_PARITY_EN
   ,
   input  logic            parity_inject,
   output logic            parity_err
`endif
);
`ifdef IMEM_PARITY_EN
   localparam int MEM_W = 33;
`else
   localparam int MEM_W = 32;
`endif
   logic              we, bad_addr, perr;
   logic [ADDR_W-1:0] waddr, idx;
   logic [31:0]       wdata;
   logic [MEM_W-1:0]  rd;
   logic [MEM_W-1:0]  mem [DEPTH_WORDS] = '{default: '0};
   imem_byte_loader #(.DEPTH_WORDS(DEPTH_WORDS)) u_loader (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_start(load_start),
      .load_words(load_words),
      .load_byte (load_byte),
      .load_valid(load_valid),
      .load_ready(load_ready),
      .busy      (busy),
      .load_done (load_done),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata)
   );
   assign idx = address[ADDR_W+1:2];
   assign rd = mem[idx];
   assign bad_addr = (address[1:0] != 2'b00) || ((address >> (ADDR_W + 2)) != 32'd0);
`ifdef IMEM_PARITY_EN
   always_ff @(posedge clk) if (we) mem[waddr] <= {^wdata ^ parity_inject, wdata};
   assign perr = !busy && !bad_addr && (^rd);
   assign parity_err = perr;
`else
   always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
   assign perr = 1'b0;
`endif
   // a fetch during load sees a NOP, never a fault, so the stalled core stays quiet
   assign fetch_fault = !busy && bad_addr;
   assign data = (busy || bad_addr || perr) ? NOP_WORD : rd[31:0];
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb_instr_mem_responder: scoreboard bench for instr_mem_responder (DEPTH_WORDS = 16).
module tb_instr_mem_responder;
   localparam int DEPTH = 16;
   localparam int AW = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] d;
      logic        f;
   } exp_t;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] data;
   logic        fetch_fault, load_start = 1'b0, load_valid = 1'b0;
   logic [AW:0] load_words = '0;
   logic [7:0]  load_byte = '0;
   logic        load_ready, busy, load_done;
`ifdef IMEM_PARITY_EN
   logic        parity_inject = 1'b0, parity_err;
`endif

   int          n_checks = 0, n_fail = 0, rdy_cnt = 0;
   logic [31:0] model [DEPTH];
   exp_t        q [$];

   instr_mem_responder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .data       (data),
      .fetch_fault(fetch_fault),
      .load_start (load_start),
      .load_words (load_words),
      .load_byte  (load_byte),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .busy       (busy),
      .load_done  (load_done)
`ifdef IMEM_PARITY_EN
      ,
      .parity_inject(parity_inject),
      .parity_err   (parity_err)
`endif
   );

   always #5 clk = ~clk;
   always @(negedge clk) rdy_cnt <= rdy_cnt + int'(load_ready);

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      load_byte = b;
      load_valid = 1'b1;
      @(negedge clk);
      while (!load_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("ready", {31'b0, load_ready}, 32'd1);
      check("nop_busy", data, NOP);
      check("nofault_busy", {31'b0, fetch_fault}, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic drain();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         address = e.addr;
         @(negedge clk);
         check("rd_data", data, e.d);
         check("rd_fault", {31'b0, fetch_fault}, {31'b0, e.f});
         @(posedge clk); #1;
      end
   endtask

   task automatic load(input int nw, input logic [31:0] w[$], input int nbytes,
                       input bit toggle, input bit abort);
      int eff, rdy0;
      logic [31:0] cur;
      eff = (nw > DEPTH) ? DEPTH : nw;
      address = 32'h2;
      load_words = (AW + 1)'(nw);
      load_start = 1'b1;
      @(posedge clk); #1;
      load_start = 1'b0;
      if (eff == 0) begin
         @(negedge clk);
         check("done_zero", {31'b0, load_done}, 32'd1);
         check("busy_zero", {31'b0, busy}, 32'd0);
         @(negedge clk);
         check("done_zero_end", {31'b0, load_done}, 32'd0);
         @(posedge clk); #1;
         return;
      end
      rdy0 = rdy_cnt;
      for (int i = 0; i < nbytes; i++) begin
         if (toggle) begin
            load_valid = 1'b0;
            @(posedge clk); #1;
         end
         cur = w[i / 4];
         send_byte(cur[(i % 4) * 8 +: 8]);
         if (i % 4 == 3) begin
            model[i / 4] = cur;
            q.push_back('{addr: 32'(i / 4) * 4, d: cur, f: 1'b0});
         end
      end
      load_valid = 1'b0;
      if (abort) begin
         reset_n = 1'b0;
         #1;
         check("rst_busy", {31'b0, busy}, 32'd0);
         check("rst_ready", {31'b0, load_ready}, 32'd0);
         #1 reset_n = 1'b1;
         @(posedge clk); #1;
         return;
      end
      @(negedge clk);
      check("done_pulse", {31'b0, load_done}, 32'd1);
      check("busy_done", {31'b0, busy}, 32'd1);
      check("ready_done", {31'b0, load_ready}, 32'd0);
      @(negedge clk);
      check("done_end", {31'b0, load_done}, 32'd0);
      check("busy_end", {31'b0, busy}, 32'd0);
      #1;
      check("ready_cycles", 32'(rdy_cnt - rdy0), 32'((toggle ? 2 : 1) * nbytes));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] w[$];
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      check("rst_data", data, 32'h0);
      check("rst_fault", {31'b0, fetch_fault}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_ready", {31'b0, load_ready}, 32'd0);
      check("rst_done", {31'b0, load_done}, 32'd0);
      @(posedge clk); #1;

      w = '{32'h0050_0013, 32'h0010_0093};
      load(2, w, 8, 1'b0, 1'b0);
      q.push_back('{addr: 32'h2, d: NOP, f: 1'b1});
      q.push_back('{addr: 32'(4 * DEPTH), d: NOP, f: 1'b1});
      q.push_back('{addr: 32'h8000_0000, d: NOP, f: 1'b1});
      q.push_back('{addr: 32'h8, d: 32'h0, f: 1'b0});
      drain();

      w = '{32'hDEAD_BEEF};
      load(1, w, 4, 1'b1, 1'b0);
      drain();

      w = '{32'h1234_5678, 32'hCAFE_F00D, 32'h0BAD_0BAD};
      load(3, w, 6, 1'b0, 1'b1);
      q.push_back('{addr: 32'h4, d: model[1], f: 1'b0});
      q.push_back('{addr: 32'h8, d: model[2], f: 1'b0});
      drain();
      load(0, w, 0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) q.push_back('{addr: 32'(i * 4), d: model[i], f: 1'b0});
      drain();

      w = {};
      for (int i = 0; i < DEPTH; i++) w.push_back(32'hA000_0000 + 32'(i) * 32'h0001_0203);
      load(20, w, 4 * DEPTH, 1'b0, 1'b0);
      q = {};
      for (int i = 0; i < DEPTH; i++) q.push_back('{addr: 32'(i * 4), d: model[i], f: 1'b0});
      drain();

`ifdef IMEM_PARITY_EN
      w = '{32'h0000_0001};
      parity_inject = 1'b1;
      load(1, w, 4, 1'b0, 1'b0);
      parity_inject = 1'b0;
      q = {};
      address = 32'h0;
      @(negedge clk);
      check("perr_set", {31'b0, parity_err}, 32'd1);
      check("perr_data", data, NOP);
      @(posedge clk); #1;
      load(1, w, 4, 1'b0, 1'b0);
      address = 32'h0;
      @(negedge clk);
      check("perr_clr", {31'b0, parity_err}, 32'd0);
      @(posedge clk); #1;
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
